tart_bram_asym: RTL and testbench

Parametrised, single-clock, asymmetric-width true dual-port block SRAM model and successor to the fixed 8-bit/32-bit RAMB16 model. Port A is narrow; port B is RATIO times wider and addresses the same storage. Compared with the fixed model, it adds per-lane write enables on the wide port, selectable write modes, an optional output pipeline register, read-valid strobes and collision flagging. It sits between the correlator/visibility capture logic (wide side) and the SPI readback path (narrow side).

---
 rtl/tart_bram_asym.sv | 209 ++++++++++++++++++++
 tb/tb_tart_bram_asym.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tart_bram_asym.sv
// tart_bram_asym: single-clock asymmetric-width true dual-port block RAM model.
// Port A is WIDTH_A wide. Port B is RATIO lanes of WIDTH_A over the same cells,
// with lane 0 in the least significant bits. An optional output register adds
// one cycle of latency on both ports.
module tart_bram_asym #(
  parameter int                         WIDTH_A = 8,
  parameter int                         RATIO   = 4,
  parameter int                         ABITS_B = 9,
  parameter int                         ABITS_A = ABITS_B + $clog2(RATIO),
  parameter string                      MODE    = "READ_FIRST",
  parameter int                         OUTREG  = 0,
  parameter logic [WIDTH_A-1:0]         SRVAL_A = '0,
  parameter logic [WIDTH_A*RATIO-1:0]   SRVAL_B = '0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       ena,
  input  logic                       wea,
  input  logic                       ssra,
  input  logic [ABITS_A-1:0]         addra,
  input  logic [WIDTH_A-1:0]         dia,
  output logic [WIDTH_A-1:0]         doa,
  output logic                       vlda,
  input  logic                       enb,
  input  logic [RATIO-1:0]           web,
  input  logic                       ssrb,
  input  logic [ABITS_B-1:0]         addrb,
  input  logic [WIDTH_A*RATIO-1:0]   dib,
  output logic [WIDTH_A*RATIO-1:0]   dob,
  output logic                       vldb,
  output logic                       collision
);

  localparam int WB          = WIDTH_A * RATIO;
  localparam int LBITS       = $clog2(RATIO);
  localparam int LW          = (LBITS == 0) ? 1 : LBITS;
  localparam bit WRITE_FIRST = (MODE == "WRITE_FIRST");
  localparam bit NO_CHANGE   = (MODE == "NO_CHANGE");

  // Storage is kept as wide words; port A selects one lane of a word.
  logic [WB-1:0]      mem_q [2**ABITS_B];

  logic [ABITS_B-1:0] word_a_s;
  logic [LW-1:0]      lane_a_s;
  logic               a_wr_s;
  logic [RATIO-1:0]   b_wr_s;
  logic [WIDTH_A-1:0] a_old_s;
  logic [WIDTH_A-1:0] a_rd_s;
  logic [WB-1:0]      b_old_s;
  logic [WB-1:0]      b_rd_s;
  logic               a_rdok_s;
  logic               b_rdok_s;
  logic               coll_s;

  logic [WIDTH_A-1:0] a_dat_q, a_dat_d;
  logic               a_vld_q, a_vld_d;
  logic [WB-1:0]      b_dat_q, b_dat_d;
  logic               b_vld_q, b_vld_d;
  logic               coll_q;

  assign word_a_s = addra[ABITS_A-1 -: ABITS_B];
  assign a_wr_s   = ena & wea;
  assign b_wr_s   = {RATIO{enb}} & web;

  if (LBITS == 0) begin : g_lane_single
    assign lane_a_s = '0;
  end else begin : g_lane_multi
    assign lane_a_s = addra[LBITS-1:0];
  end

  // Storage update; port A goes first so a same-lane port B write wins.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (a_wr_s) begin
        mem_q[word_a_s][int'(lane_a_s)*WIDTH_A +: WIDTH_A] <= dia;
      end
      for (int k = 0; k < RATIO; k++) begin
        if (b_wr_s[k]) begin
          mem_q[addrb][k*WIDTH_A +: WIDTH_A] <= dib[k*WIDTH_A +: WIDTH_A];
        end
      end
    end
  end

  // Read data per write mode, read permission and address-conflict detection.
  always_comb begin
    a_old_s = mem_q[word_a_s][int'(lane_a_s)*WIDTH_A +: WIDTH_A];
    b_old_s = mem_q[addrb];
    if (WRITE_FIRST && a_wr_s) begin
      a_rd_s = dia;
    end else begin
      a_rd_s = a_old_s;
    end
    b_rd_s = b_old_s;
    for (int k = 0; k < RATIO; k++) begin
      if (WRITE_FIRST && b_wr_s[k]) begin
        b_rd_s[k*WIDTH_A +: WIDTH_A] = dib[k*WIDTH_A +: WIDTH_A];
      end else begin
        b_rd_s[k*WIDTH_A +: WIDTH_A] = b_old_s[k*WIDTH_A +: WIDTH_A];
      end
    end
    a_rdok_s = ena & ~(NO_CHANGE & a_wr_s);
    b_rdok_s = enb & ~(NO_CHANGE & (|b_wr_s));
    // Port A touches one cell; port B touches every lane of its word.
    coll_s   = ena & enb & (word_a_s == addrb) & (a_wr_s | b_wr_s[lane_a_s]);
  end

  // First output stage next state: SSR value, fresh read data, or hold.
  always_comb begin
    a_dat_d = a_dat_q;
    a_vld_d = 1'b0;
    if (ena && ssra) begin
      if (OUTREG == 0) begin
        a_dat_d = SRVAL_A;
      end else begin
        a_dat_d = a_dat_q;
      end
    end else if (a_rdok_s) begin
      a_dat_d = a_rd_s;
      a_vld_d = 1'b1;
    end else begin
      a_dat_d = a_dat_q;
    end

    b_dat_d = b_dat_q;
    b_vld_d = 1'b0;
    if (enb && ssrb) begin
      if (OUTREG == 0) begin
        b_dat_d = SRVAL_B;
      end else begin
        b_dat_d = b_dat_q;
      end
    end else if (b_rdok_s) begin
      b_dat_d = b_rd_s;
      b_vld_d = 1'b1;
    end else begin
      b_dat_d = b_dat_q;
    end
  end

  // First output stage registers; reset discards any access in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_dat_q <= SRVAL_A;
      a_vld_q <= 1'b0;
      b_dat_q <= SRVAL_B;
      b_vld_q <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      a_dat_q <= a_dat_d;
      a_vld_q <= a_vld_d;
      b_dat_q <= b_dat_d;
      b_vld_q <= b_vld_d;
      coll_q  <= coll_s;
    end
  end

  if (OUTREG != 0) begin : g_outreg
    logic [WIDTH_A-1:0] doa_q;
    logic               vlda_q;
    logic [WB-1:0]      dob_q;
    logic               vldb_q;
    logic               coll2_q;

    // Output pipeline stage; SSR overrides it and drops the pending read.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        doa_q   <= SRVAL_A;
        vlda_q  <= 1'b0;
        dob_q   <= SRVAL_B;
        vldb_q  <= 1'b0;
        coll2_q <= 1'b0;
      end else begin
        if (ena && ssra) begin
          doa_q  <= SRVAL_A;
          vlda_q <= 1'b0;
        end else if (a_vld_q) begin
          doa_q  <= a_dat_q;
          vlda_q <= 1'b1;
        end else begin
          vlda_q <= 1'b0;
        end
        if (enb && ssrb) begin
          dob_q  <= SRVAL_B;
          vldb_q <= 1'b0;
        end else if (b_vld_q) begin
          dob_q  <= b_dat_q;
          vldb_q <= 1'b1;
        end else begin
          vldb_q <= 1'b0;
        end
        coll2_q <= coll_q;
      end
    end

    assign doa       = doa_q;
    assign vlda      = vlda_q;
    assign dob       = dob_q;
    assign vldb      = vldb_q;
    assign collision = coll2_q;
  end else begin : g_direct
    assign doa       = a_dat_q;
    assign vlda      = a_vld_q;
    assign dob       = b_dat_q;
    assign vldb      = b_vld_q;
    assign collision = coll_q;
  end

endmodule

// File: tb/tb_tart_bram_asym.sv
// Bench for tart_bram_asym: a table of directed vectors on a READ_FIRST
// instance, then hand sequences covering WRITE_FIRST with the output
// register, NO_CHANGE, SSR flushing and asynchronous reset mid-read.
module tb_tart_bram_asym;

  logic        clock;
  logic        reset_n;
  logic        ena, wea, ssra;
  logic [10:0] addra;
  logic [7:0]  dia;
  logic        enb;
  logic [3:0]  web;
  logic        ssrb;
  logic [8:0]  addrb;
  logic [31:0] dib;

  logic [7:0]  doa0, doa1, doa2;
  logic        vlda0, vlda1, vlda2;
  logic [31:0] dob0, dob1, dob2;
  logic        vldb0, vldb1, vldb2;
  logic        coll0, coll1, coll2;

  int n_chk;
  int n_fail;

  tart_bram_asym #(.MODE("READ_FIRST"), .OUTREG(0),
                   .SRVAL_A(8'h3C), .SRVAL_B(32'hCAFE0000)) u0 (
    .clock(clock), .reset_n(reset_n),
    .ena(ena), .wea(wea), .ssra(ssra), .addra(addra), .dia(dia),
    .doa(doa0), .vlda(vlda0),
    .enb(enb), .web(web), .ssrb(ssrb), .addrb(addrb), .dib(dib),
    .dob(dob0), .vldb(vldb0), .collision(coll0));

  tart_bram_asym #(.MODE("WRITE_FIRST"), .OUTREG(1),
                   .SRVAL_A(8'h00), .SRVAL_B(32'h0BAD0000)) u1 (
    .clock(clock), .reset_n(reset_n),
    .ena(ena), .wea(wea), .ssra(ssra), .addra(addra), .dia(dia),
    .doa(doa1), .vlda(vlda1),
    .enb(enb), .web(web), .ssrb(ssrb), .addrb(addrb), .dib(dib),
    .dob(dob1), .vldb(vldb1), .collision(coll1));

  tart_bram_asym #(.MODE("NO_CHANGE"), .OUTREG(0),
                   .SRVAL_A(8'h00), .SRVAL_B(32'h00000000)) u2 (
    .clock(clock), .reset_n(reset_n),
    .ena(ena), .wea(wea), .ssra(ssra), .addra(addra), .dia(dia),
    .doa(doa2), .vlda(vlda2),
    .enb(enb), .web(web), .ssrb(ssrb), .addrb(addrb), .dib(dib),
    .dob(dob2), .vldb(vldb2), .collision(coll2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        ena, wea, ssra;
    logic [10:0] addra;
    logic [7:0]  dia;
    logic        enb;
    logic [3:0]  web;
    logic        ssrb;
    logic [8:0]  addrb;
    logic [31:0] dib;
    logic        ca;
    logic [7:0]  edoa;
    logic        evlda;
    logic        cb;
    logic [31:0] edob;
    logic        evldb;
    logic        ecoll;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic a_en, input logic a_we, input logic a_ss,
    input logic [10:0] a_ad, input logic [7:0] a_di,
    input logic b_en, input logic [3:0] b_we, input logic b_ss,
    input logic [8:0] b_ad, input logic [31:0] b_di,
    input logic ca, input logic [7:0] edoa, input logic evlda,
    input logic cb, input logic [31:0] edob, input logic evldb,
    input logic ecoll);
    vec_t v;
    v.ena = a_en; v.wea = a_we; v.ssra = a_ss; v.addra = a_ad; v.dia = a_di;
    v.enb = b_en; v.web = b_we; v.ssrb = b_ss; v.addrb = b_ad; v.dib = b_di;
    v.ca = ca; v.edoa = edoa; v.evlda = evlda;
    v.cb = cb; v.edob = edob; v.evldb = evldb; v.ecoll = ecoll;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic a_en, input logic a_we, input logic a_ss,
                       input logic [10:0] a_ad, input logic [7:0] a_di,
                       input logic b_en, input logic [3:0] b_we, input logic b_ss,
                       input logic [8:0] b_ad, input logic [31:0] b_di);
    ena = a_en; wea = a_we; ssra = a_ss; addra = a_ad; dia = a_di;
    enb = b_en; web = b_we; ssrb = b_ss; addrb = b_ad; dib = b_di;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 11'd0, 8'h00, 1'b0, 4'h0, 1'b0, 9'd0, 32'h0);
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " u0 doa"},  {24'h0, doa0}, 32'h0000003C);
    chk({tag, " u0 vlda"}, {31'h0, vlda0}, 32'h0);
    chk({tag, " u0 dob"},  dob0, 32'hCAFE0000);
    chk({tag, " u0 vldb"}, {31'h0, vldb0}, 32'h0);
    chk({tag, " u0 coll"}, {31'h0, coll0}, 32'h0);
    chk({tag, " u1 dob"},  dob1, 32'h0BAD0000);
    chk({tag, " u1 vldb"}, {31'h0, vldb1}, 32'h0);
    chk({tag, " u1 vlda"}, {31'h0, vlda1}, 32'h0);
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    idle();

    // Vectors for u0 (READ_FIRST, latency 1, SRVAL_A=3C, SRVAL_B=CAFE0000).
    // Narrow writes to 0..3, then wide read of word 0.
    tv.push_back(mk(1'b1,1'b1,1'b0,11'd0,8'hA5, 1'b0,4'h0,1'b0,9'd0,32'h0,        1'b0,8'h00,1'b1, 1'b1,32'hCAFE0000,1'b0, 1'b0));
    tv.push_back(mk(1'b1,1'b1,1'b0,11'd1,8'h5A, 1'b0,4'h0,1'b0,9'd0,32'h0,        1'b0,8'h00,1'b1, 1'b1,32'hCAFE0000,1'b0, 1'b0));
    tv.push_back(mk(1'b1,1'b1,1'b0,11'd2,8'hA5, 1'b0,4'h0,1'b0,9'd0,32'h0,        1'b0,8'h00,1'b1, 1'b1,32'hCAFE0000,1'b0, 1'b0));
    tv.push_back(mk(1'b1,1'b1,1'b0,11'd3,8'h5A, 1'b0,4'h0,1'b0,9'd0,32'h0,        1'b0,8'h00,1'b1, 1'b1,32'hCAFE0000,1'b0, 1'b0));
    tv.push_back(mk(1'b0,1'b0,1'b0,11'd0,8'h00, 1'b1,4'h0,1'b0,9'd0,32'h0,        1'b0,8'h00,1'b0, 1'b1,32'h5AA55AA5,1'b1, 1'b0));
    // Wide write to word 2, narrow reads of 8..11.
    tv.push_back(mk(1'b0,1'b0,1'b0,11'd0,8'h00, 1'b1,4'hF,1'b0,9'd2,32'hDEADBEEF, 1'b0,8'h00,1'b0, 1'b0,32'h0,1'b1, 1'b0));
    tv.push_back(mk(1'b1,1'b0,1'b0,11'd8,8'h00, 1'b0,4'h0,1'b0,9'd0,32'h0,        1'b1,8'hEF,1'b1, 1'b0,32'h0,1'b0, 1'b0));
    tv.push_back(mk(1'b1,1'b0,1'b0,11'd9,8'h00, 1'b0,4'h0,1'b0,9'd0,32'h0,        1'b1,8'hBE,1'b1, 1'b0,32'h0,1'b0, 1'b0));
    tv.push_back(mk(1'b1,1'b0,1'b0,11'd10,8'h00,1'b0,4'h0,1'b0,9'd0,32'h0,        1'b1,8'hAD,1'b1, 1'b0,32'h0,1'b0, 1'b0));
    tv.push_back(mk(1'b1,1'b0,1'b0,11'd11,8'h00,1'b0,4'h0,1'b0,9'd0,32'h0,        1'b1,8'hDE,1'b1, 1'b0,32'h0,1'b0, 1'b0));
    // Lane-masked write, READ_FIRST returns old word, then read back.
    tv.push_back(mk(1'b0,1'b0,1'b0,11'd0,8'h00, 1'b1,4'h5,1'b0,9'd2,32'h11223344, 1'b1,8'hDE,1'b0, 1'b1,32'hDEADBEEF,1'b1, 1'b0));
    tv.push_back(mk(1'b0,1'b0,1'b0,11'd0,8'h00, 1'b1,4'h0,1'b0,9'd2,32'h0,        1'b1,8'hDE,1'b0, 1'b1,32'hDE22BE44,1'b1, 1'b0));
    tv.push_back(mk(1'b0,1'b0,1'b0,11'd0,8'h00, 1'b1,4'hF,1'b0,9'd0,32'h01020304, 1'b1,8'hDE,1'b0, 1'b1,32'h5AA55AA5,1'b1, 1'b0));
    tv.push_back(mk(1'b0,1'b0,1'b0,11'd0,8'h00, 1'b1,4'h0,1'b0,9'd0,32'h0,        1'b1,8'hDE,1'b0, 1'b1,32'h01020304,1'b1, 1'b0));
    // Write/write collision on address 5 = word 1 lane 1; port B wins.
    tv.push_back(mk(1'b1,1'b1,1'b0,11'd5,8'h77, 1'b1,4'h2,1'b0,9'd1,32'h00009900, 1'b0,8'h00,1'b1, 1'b0,32'h0,1'b1, 1'b1));
    tv.push_back(mk(1'b1,1'b0,1'b0,11'd5,8'h00, 1'b0,4'h0,1'b0,9'd0,32'h0,        1'b1,8'h99,1'b1, 1'b0,32'h0,1'b0, 1'b0));
    // Read/write collision: A reads old cell while B writes it.
    tv.push_back(mk(1'b1,1'b0,1'b0,11'd8,8'h00, 1'b1,4'h1,1'b0,9'd2,32'h000000AA, 1'b1,8'h44,1'b1, 1'b1,32'hDE22BE44,1'b1, 1'b1));
    tv.push_back(mk(1'b1,1'b0,1'b0,11'd8,8'h00, 1'b0,4'h0,1'b0,9'd0,32'h0,        1'b1,8'hAA,1'b1, 1'b1,32'hDE22BE44,1'b0, 1'b0));
    // No conflicts: read/read same word, write to a different word.
    tv.push_back(mk(1'b1,1'b0,1'b0,11'd9,8'h00, 1'b1,4'h0,1'b0,9'd2,32'h0,        1'b1,8'hBE,1'b1, 1'b1,32'hDE22BEAA,1'b1, 1'b0));
    tv.push_back(mk(1'b1,1'b1,1'b0,11'd0,8'h55, 1'b1,4'h0,1'b0,9'd2,32'h0,        1'b1,8'h04,1'b1, 1'b1,32'hDE22BEAA,1'b1, 1'b0));
    // SSR on both ports, SSR without enable, SSR with write.
    tv.push_back(mk(1'b1,1'b0,1'b1,11'd1,8'h00, 1'b1,4'h0,1'b1,9'd0,32'h0,        1'b1,8'h3C,1'b0, 1'b1,32'hCAFE0000,1'b0, 1'b0));
    tv.push_back(mk(1'b0,1'b0,1'b1,11'd1,8'h00, 1'b1,4'h0,1'b0,9'd0,32'h0,        1'b1,8'h3C,1'b0, 1'b1,32'h01020355,1'b1, 1'b0));
    tv.push_back(mk(1'b0,1'b0,1'b0,11'd0,8'h00, 1'b1,4'hF,1'b1,9'd3,32'hCAFEBABE, 1'b1,8'h3C,1'b0, 1'b1,32'hCAFE0000,1'b0, 1'b0));
    tv.push_back(mk(1'b0,1'b0,1'b0,11'd0,8'h00, 1'b1,4'h0,1'b0,9'd3,32'h0,        1'b1,8'h3C,1'b0, 1'b1,32'hCAFEBABE,1'b1, 1'b0));
    // Same word, different lane: no collision.
    tv.push_back(mk(1'b1,1'b0,1'b0,11'd9,8'h00, 1'b1,4'h1,1'b0,9'd2,32'h000000AA, 1'b1,8'hBE,1'b1, 1'b1,32'hDE22BEAA,1'b1, 1'b0));

    repeat (2) @(negedge clock);
    chk_reset_vals("reset");
    reset_n = 1'b1;

    foreach (tv[i]) begin
      drive(tv[i].ena, tv[i].wea, tv[i].ssra, tv[i].addra, tv[i].dia,
            tv[i].enb, tv[i].web, tv[i].ssrb, tv[i].addrb, tv[i].dib);
      step();
      if (tv[i].ca) chk($sformatf("v%0d doa", i), {24'h0, doa0}, {24'h0, tv[i].edoa});
      chk($sformatf("v%0d vlda", i), {31'h0, vlda0}, {31'h0, tv[i].evlda});
      if (tv[i].cb) chk($sformatf("v%0d dob", i), dob0, tv[i].edob);
      chk($sformatf("v%0d vldb", i), {31'h0, vldb0}, {31'h0, tv[i].evldb});
      chk($sformatf("v%0d coll", i), {31'h0, coll0}, {31'h0, tv[i].ecoll});
    end

    // Write modes: word 0 = 01020304, then write FFFFFFFF with read.
    drive(1'b0, 1'b0, 1'b0, 11'd0, 8'h00, 1'b1, 4'hF, 1'b0, 9'd0, 32'h01020304);
    step();
    chk("h1 u0 dob", dob0, 32'h01020355);
    chk("h1 u2 dob", dob2, 32'hCAFEBABE);
    chk("h1 u2 vldb", {31'h0, vldb2}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 11'd0, 8'h00, 1'b1, 4'hF, 1'b0, 9'd0, 32'hFFFFFFFF);
    step();
    chk("h2 rf dob", dob0, 32'h01020304);
    chk("h2 rf vldb", {31'h0, vldb0}, 32'h1);
    chk("h2 nc dob", dob2, 32'hCAFEBABE);
    chk("h2 nc vldb", {31'h0, vldb2}, 32'h0);
    chk("h2 wf dob", dob1, 32'h01020304);
    chk("h2 wf vldb", {31'h0, vldb1}, 32'h1);
    idle();
    step();
    chk("h3 wf dob", dob1, 32'hFFFFFFFF);
    chk("h3 wf vldb", {31'h0, vldb1}, 32'h1);
    chk("h3 rf vldb", {31'h0, vldb0}, 32'h0);
    step();
    chk("h4 wf vldb", {31'h0, vldb1}, 32'h0);
    chk("h4 wf dob", dob1, 32'hFFFFFFFF);

    // NO_CHANGE still stores; plain read returns the new word.
    drive(1'b0, 1'b0, 1'b0, 11'd0, 8'h00, 1'b1, 4'h0, 1'b0, 9'd0, 32'h0);
    step();
    chk("h5 nc dob", dob2, 32'hFFFFFFFF);
    chk("h5 nc vldb", {31'h0, vldb2}, 32'h1);
    step();
    chk("h6 wf vldb", {31'h0, vldb1}, 32'h1);
    // SSR on the pipelined port flushes the read still in the first stage.
    drive(1'b0, 1'b0, 1'b0, 11'd0, 8'h00, 1'b1, 4'h0, 1'b1, 9'd0, 32'h0);
    step();
    chk("h7 wf ssr dob", dob1, 32'h0BAD0000);
    chk("h7 wf ssr vldb", {31'h0, vldb1}, 32'h0);
    chk("h7 rf ssr dob", dob0, 32'hCAFE0000);
    idle();
    step();
    chk("h8 wf flush vldb", {31'h0, vldb1}, 32'h0);
    chk("h8 wf flush dob", dob1, 32'h0BAD0000);

    // Asynchronous reset in the middle of a read.
    drive(1'b1, 1'b0, 1'b0, 11'd8, 8'h00, 1'b1, 4'h0, 1'b0, 9'd2, 32'h0);
    @(posedge clock);
    #1;
    chk("pre-rst doa", {24'h0, doa0}, 32'h000000AA);
    chk("pre-rst vlda", {31'h0, vlda0}, 32'h1);
    chk("pre-rst dob", dob0, 32'hDE22BEAA);
    #1;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("mid-rst");
    idle();
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    chk_reset_vals("post-rst");
    drive(1'b1, 1'b0, 1'b0, 11'd8, 8'h00, 1'b1, 4'h0, 1'b0, 9'd2, 32'h0);
    step();
    chk("kept doa", {24'h0, doa0}, 32'h000000AA);
    chk("kept vlda", {31'h0, vlda0}, 32'h1);
    chk("kept dob", dob0, 32'hDE22BEAA);
    chk("kept vldb", {31'h0, vldb0}, 32'h1);
    idle();
    step();
    chk("kept u1 dob", dob1, 32'hDE22BEAA);
    chk("kept u1 vldb", {31'h0, vldb1}, 32'h1);
    chk("kept u1 doa", {24'h0, doa1}, 32'h000000AA);
    chk("u0 vlda single", {31'h0, vlda0}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
